// File: rtl/axi4_lite_master_write.sv
// AXI4-Lite single-beat write master: captures one request, drives AW/W, collects B.
// Latency: AW/W handshakes 1 edge after start, B 1 edge later, done_o the cycle after (ready slave).
// Backpressure: AW/W VALID held until READY; B wait bounded by RESP_TIMEOUT, then error completion.
module axi4_lite_master_write #(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int RESP_TIMEOUT   = 256
) (
  input  logic                        clk_i,
  input  logic                        arst_i,
  input  logic                        start_write_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   addr_i,
  input  logic [AXI_DATA_WIDTH-1:0]   data_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] strb_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        error_o,
  output logic                        AW_VALID,
  output logic [AXI_ADDR_WIDTH-1:0]   AW_ADDR,
  output logic [2:0]                  AW_PROT,
  input  logic                        AW_READY,
  output logic                        W_VALID,
  output logic [AXI_DATA_WIDTH-1:0]   W_DATA,
  output logic [AXI_DATA_WIDTH/8-1:0] W_STRB,
  input  logic                        W_READY,
  output logic                        B_READY,
  input  logic                        B_VALID,
  input  logic [1:0]                  B_RESP
);

  localparam int STRB_W = AXI_DATA_WIDTH / 8;
  localparam int CNT_W  = (RESP_TIMEOUT > 2) ? $clog2(RESP_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESP_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_RESP,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [AXI_ADDR_WIDTH-1:0] r_addr;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [STRB_W-1:0]         r_strb;
  logic                      r_aw_valid;
  logic                      r_w_valid;
  logic                      r_b_ready;
  logic                      r_aw_done;
  logic                      r_w_done;
  logic                      r_done;
  logic                      r_error;
  logic [CNT_W-1:0]          r_cnt;

  logic w_aw_hs;
  logic w_w_hs;
  logic w_b_hs;
  logic w_send_fin;
  logic w_timeout;

  assign w_aw_hs    = r_aw_valid & AW_READY;
  assign w_w_hs     = r_w_valid & W_READY;
  assign w_b_hs     = r_b_ready & B_VALID;
  // Both channels may finish on the same edge or on different edges.
  assign w_send_fin = (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);
  assign w_timeout  = (r_cnt == CNT_LAST);

  // State register.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; a B handshake takes priority over the timeout (both go to DONE).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start_write_i) w_state_nxt = S_SEND;
      S_SEND: if (w_send_fin) w_state_nxt = S_RESP;
      S_RESP: if (w_b_hs || w_timeout) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Registered datapath and channel controls, so no input reaches an output combinationally.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_addr     <= '0;
      r_data     <= '0;
      r_strb     <= '0;
      r_aw_valid <= 1'b0;
      r_w_valid  <= 1'b0;
      r_b_ready  <= 1'b0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done  <= 1'b0;
          r_error <= 1'b0;
          if (start_write_i) begin
            r_addr     <= addr_i;
            r_data     <= data_i;
            r_strb     <= strb_i;
            r_aw_valid <= 1'b1;
            r_w_valid  <= 1'b1;
          end
        end
        S_SEND: begin
          if (w_aw_hs) begin
            r_aw_valid <= 1'b0;
            r_aw_done  <= 1'b1;
          end
          if (w_w_hs) begin
            r_w_valid <= 1'b0;
            r_w_done  <= 1'b1;
          end
          // Later assignments override the flag sets above when leaving SEND.
          if (w_send_fin) begin
            r_b_ready <= 1'b1;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_cnt     <= '0;
          end
        end
        S_RESP: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_b_hs) begin
            r_b_ready <= 1'b0;
            r_done    <= 1'b1;
            r_error   <= (B_RESP != 2'b00);
          end else if (w_timeout) begin
            r_b_ready <= 1'b0;
            r_done    <= 1'b1;
            r_error   <= 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_error <= 1'b0;
        end
        default: begin
          r_done  <= 1'b0;
          r_error <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o   = (r_state != S_IDLE);
  assign done_o   = r_done;
  assign error_o  = r_error;
  assign AW_VALID = r_aw_valid;
  assign AW_ADDR  = r_addr;
  assign AW_PROT  = 3'b000;
  assign W_VALID  = r_w_valid;
  assign W_DATA   = r_data;
  assign W_STRB   = r_strb;
  assign B_READY  = r_b_ready;

endmodule

// File: tb/tb_axi4_lite_master_write.sv
// Testbench for axi4_lite_master_write: directed transactions, scoreboard of completions.
// Latency and handshake shape checked in the stimulus thread; completions checked by a monitor.
// Slave readiness and B responses come from a configurable responder process.
module tb_axi4_lite_master_write;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        start = 1'b0;
  logic [63:0] addr = '0;
  logic [31:0] data = '0;
  logic [3:0]  strb = '0;
  logic        busy, done, err;
  logic        awv, wv, bready;
  logic [63:0] awaddr;
  logic [2:0]  awprot;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        aw_ready = 1'b1;
  logic        w_ready = 1'b1;
  logic        b_valid = 1'b0;
  logic [1:0]  b_resp = 2'b00;

  int   aw_delay = 0;
  int   w_delay = 0;
  bit   b_en = 1'b1;
  logic [1:0] b_resp_cfg = 2'b00;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        err;
  } exp_t;
  exp_t sb[$];

  axi4_lite_master_write #(
    .AXI_ADDR_WIDTH(64),
    .AXI_DATA_WIDTH(32),
    .RESP_TIMEOUT(8)
  ) dut (
    .clk_i(clk), .arst_i(arst), .start_write_i(start),
    .addr_i(addr), .data_i(data), .strb_i(strb),
    .busy_o(busy), .done_o(done), .error_o(err),
    .AW_VALID(awv), .AW_ADDR(awaddr), .AW_PROT(awprot), .AW_READY(aw_ready),
    .W_VALID(wv), .W_DATA(wdata), .W_STRB(wstrb), .W_READY(w_ready),
    .B_READY(bready), .B_VALID(b_valid), .B_RESP(b_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_awvalid"}, 64'(awv), 64'd0);
    chk({tag, "_wvalid"},  64'(wv), 64'd0);
    chk({tag, "_bready"},  64'(bready), 64'd0);
    chk({tag, "_awaddr"},  awaddr, 64'd0);
    chk({tag, "_wdata"},   64'(wdata), 64'd0);
    chk({tag, "_wstrb"},   64'(wstrb), 64'd0);
    chk({tag, "_busy"},    64'(busy), 64'd0);
    chk({tag, "_done"},    64'(done), 64'd0);
    chk({tag, "_error"},   64'(err), 64'd0);
  endtask

  // Drive a start for one edge; optionally record the completion the monitor should see.
  task automatic drive_start(input logic [63:0] a, input logic [31:0] d, input logic [3:0] s,
                             input bit push, input bit e);
    exp_t x;
    addr = a; data = d; strb = s; start = 1'b1;
    if (push) begin
      x.addr = a; x.data = d; x.strb = s; x.err = e;
      sb.push_back(x);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // From just after the start edge, count edges to done_o and profile channel activity.
  task automatic observe(input logic [63:0] ea, input logic [31:0] ed,
                         output int lat, output int aw_hi, output int w_hi, output int b_hi,
                         output bit early_b, output bit unstable);
    lat = 0; aw_hi = 0; w_hi = 0; b_hi = 0; early_b = 1'b0; unstable = 1'b0;
    while (!done && lat < 100) begin
      if (awv) aw_hi++;
      if (wv) w_hi++;
      if (bready) b_hi++;
      if (bready && awv) early_b = 1'b1;
      if (awaddr !== ea || wdata !== ed) unstable = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk("done_seen", 64'(done), 64'd1);
  endtask

  task automatic after_done(input string tag);
    @(posedge clk); #1;
    chk({tag, "_done_cleared"}, 64'(done), 64'd0);
    chk({tag, "_err_cleared"},  64'(err), 64'd0);
    chk({tag, "_idle"},         64'(busy), 64'd0);
  endtask

  // Slave responder: READY after a per-channel delay, B_VALID the cycle after B_READY.
  initial begin
    int aw_cnt = 0;
    int w_cnt = 0;
    forever begin
      @(posedge clk); #2;
      if (awv) begin aw_cnt++; aw_ready = (aw_cnt >= aw_delay); end
      else begin aw_cnt = 0; aw_ready = (aw_delay == 0); end
      if (wv) begin w_cnt++; w_ready = (w_cnt >= w_delay); end
      else begin w_cnt = 0; w_ready = (w_delay == 0); end
      b_valid = b_en && bready;
      b_resp  = b_resp_cfg;
    end
  end

  // Completion monitor: every done_o pulse must match the oldest outstanding request.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (!arst && done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'(done), 64'd0);
        end else begin
          x = sb.pop_front();
          chk("sb_error", 64'(err), 64'(x.err));
          chk("sb_awaddr", awaddr, x.addr);
          chk("sb_wdata", 64'(wdata), 64'(x.data));
          chk("sb_wstrb", 64'(wstrb), 64'(x.strb));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, aw_hi, w_hi, b_hi;
    bit early_b, unstable;

    // Reset state
    #1;
    chk_zero("rst");
    chk("awprot", 64'(awprot), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); arst = 1'b0;

    // Basic write, ready slave, OKAY response
    @(negedge clk);
    drive_start(64'h1000, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0);
    chk("t1_awvalid", 64'(awv), 64'd1);
    chk("t1_wvalid", 64'(wv), 64'd1);
    chk("t1_busy", 64'(busy), 64'd1);
    observe(64'h1000, 32'hDEADBEEF, lat, aw_hi, w_hi, b_hi, early_b, unstable);
    chk("t1_latency", 64'(lat), 64'd2);
    chk("t1_aw_cycles", 64'(aw_hi), 64'd1);
    chk("t1_w_cycles", 64'(w_hi), 64'd1);
    chk("t1_b_cycles", 64'(b_hi), 64'd1);
    chk("t1_stable", 64'(unstable), 64'd0);
    after_done("t1");

    // Delayed AW (4) and W (1) readiness
    aw_delay = 4; w_delay = 1;
    @(negedge clk);
    drive_start(64'h2004, 32'h12345678, 4'h3, 1'b1, 1'b0);
    observe(64'h2004, 32'h12345678, lat, aw_hi, w_hi, b_hi, early_b, unstable);
    chk("t2_aw_cycles", 64'(aw_hi), 64'd4);
    chk("t2_w_cycles", 64'(w_hi), 64'd1);
    chk("t2_b_after_aw", 64'(early_b), 64'd0);
    chk("t2_b_cycles", 64'(b_hi), 64'd1);
    chk("t2_latency", 64'(lat), 64'd5);
    chk("t2_stable", 64'(unstable), 64'd0);
    after_done("t2");
    aw_delay = 0; w_delay = 0;

    // SLVERR response
    b_resp_cfg = 2'b10;
    @(negedge clk);
    drive_start(64'h3000, 32'hCAFEF00D, 4'h8, 1'b1, 1'b1);
    observe(64'h3000, 32'hCAFEF00D, lat, aw_hi, w_hi, b_hi, early_b, unstable);
    chk("t3_latency", 64'(lat), 64'd2);
    chk("t3_error", 64'(err), 64'd1);
    after_done("t3");
    b_resp_cfg = 2'b00;

    // No B response: timeout after 8 cycles of B_READY
    b_en = 1'b0;
    @(negedge clk);
    drive_start(64'h4000, 32'h0BADF00D, 4'hC, 1'b1, 1'b1);
    observe(64'h4000, 32'h0BADF00D, lat, aw_hi, w_hi, b_hi, early_b, unstable);
    chk("t4_b_cycles", 64'(b_hi), 64'd8);
    chk("t4_bready_low", 64'(bready), 64'd0);
    chk("t4_latency", 64'(lat), 64'd9);
    chk("t4_error", 64'(err), 64'd1);
    after_done("t4");

    // Start pulsed during RESP is ignored
    @(negedge clk);
    drive_start(64'h5000, 32'h55AA55AA, 4'h1, 1'b1, 1'b0);
    @(posedge clk); #1;
    addr = 64'h9999; data = 32'h0; strb = 4'h0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t5_no_recapture", awaddr, 64'h5000);
    chk("t5_in_resp", 64'(bready), 64'd1);
    b_en = 1'b1;
    observe(64'h5000, 32'h55AA55AA, lat, aw_hi, w_hi, b_hi, early_b, unstable);
    after_done("t5");
    repeat (6) @(posedge clk);
    #1;
    chk("t5_not_queued", 64'(busy), 64'd0);

    // Reset mid-SEND aborts with no completion; restart on first edge after release
    aw_delay = 4;
    @(negedge clk);
    drive_start(64'h6000, 32'h66666666, 4'hF, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("t6_in_send", 64'(awv), 64'd1);
    #3 arst = 1'b1;
    #1;
    chk_zero("t6_rst");
    aw_delay = 0;
    @(posedge clk); #1;
    chk("t6_rst_no_done", 64'(done), 64'd0);
    @(negedge clk);
    arst = 1'b0;
    drive_start(64'h7000, 32'h77777777, 4'h7, 1'b1, 1'b0);
    chk("t6_accepted", 64'(busy), 64'd1);
    chk("t6_captured", awaddr, 64'h7000);
    observe(64'h7000, 32'h77777777, lat, aw_hi, w_hi, b_hi, early_b, unstable);
    chk("t6_latency", 64'(lat), 64'd2);
    after_done("t6");

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
